// File: rtl/div_issue_ctrl_if.sv
// Request/response handshake bundle between the execute stage and the
// divider sequencing stage (div_issue_ctrl).
//   master : execute-stage side (issues requests, consumes results)
//   slave  : div_issue_ctrl side
interface div_issue_ctrl_if #(
  parameter int unsigned TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_dividend;
  logic [31:0]      in_divisor;
  logic             in_is_rem;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_dbz;

  modport master (
    output in_valid, in_dividend, in_divisor, in_is_rem, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_dbz
  );

  modport slave (
    input  in_valid, in_dividend, in_divisor, in_is_rem, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_dbz
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Sequencing stage in front of the 32-bit combinational signed divider.
// Accepts one DIV/REM request, holds the operands on the divider for LATENCY
// cycles, then returns the sampled quotient/remainder with its tag.
// RISC-V corner cases (divide by zero, overflow, divisor == INT_MIN) bypass
// the divider and complete one cycle after acceptance.
// Optional build macro DIV_REM_FUSE_EN: one-entry result cache so a DIV/REM
// pair on identical operands needs only one divider pass.
module div_issue_ctrl #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  div_issue_ctrl_if.slave  bus,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divisor,
  input  logic [31:0]      div_quotient,
  input  logic [31:0]      div_remainder,
  output logic             busy
);

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam int unsigned CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_rem_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      res_q;
  logic [TAG_W-1:0] out_tag_q;
  logic             dbz_q;

  logic             accept;
  logic             wait_done;
  logic             op_div0;
  logic             op_ovf;
  logic             op_dmin;
  logic             fast_path;
  logic [31:0]      fast_q;
  logic [31:0]      fast_r;
  logic [31:0]      fast_res;
  logic             cache_hit;
  logic [31:0]      cache_res;

  assign accept    = (state_q == S_IDLE) && bus.in_valid && !flush;
  assign wait_done = (state_q == S_WAIT) && (cnt_q == '0);

  // Corner-case detection and the architecturally defined results for them
  always_comb begin
    op_div0 = (bus.in_divisor == '0);
    op_ovf  = (bus.in_dividend == INT_MIN) && (bus.in_divisor == '1);
    op_dmin = (bus.in_divisor == INT_MIN);
    fast_q  = '0;
    fast_r  = '0;
    if (op_div0) begin
      fast_q = '1;
      fast_r = bus.in_dividend;
    end else if (op_ovf) begin
      fast_q = INT_MIN;
      fast_r = '0;
    end else if (op_dmin) begin
      fast_q = (bus.in_dividend == INT_MIN) ? 32'd1 : 32'd0;
      fast_r = (bus.in_dividend == INT_MIN) ? 32'd0 : bus.in_dividend;
    end
    fast_path = op_div0 || op_ovf || op_dmin;
    fast_res  = bus.in_is_rem ? fast_r : fast_q;
  end

`ifdef DIV_REM_FUSE_EN
  logic        cache_vld;
  logic [31:0] cache_a;
  logic [31:0] cache_b;
  logic [31:0] cache_q;
  logic [31:0] cache_r;

  // Remember the last completed divider pass; only reset invalidates it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_vld <= 1'b0;
      cache_a   <= '0;
      cache_b   <= '0;
      cache_q   <= '0;
      cache_r   <= '0;
    end else if (wait_done && !flush) begin
      cache_vld <= 1'b1;
      cache_a   <= div_dividend;
      cache_b   <= div_divisor;
      cache_q   <= div_quotient;
      cache_r   <= div_remainder;
    end
  end

  assign cache_hit = cache_vld && (bus.in_dividend == cache_a) &&
                     (bus.in_divisor == cache_b);
  assign cache_res = bus.in_is_rem ? cache_r : cache_q;
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.in_valid) state_d = (fast_path || cache_hit) ? S_DONE : S_WAIT;
      S_WAIT: if (cnt_q == '0) state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Handshake/status outputs decoded from state
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    busy          = (state_q != S_IDLE);
  end

  // Operand capture, window countdown and result registers; out_* are only
  // written on the transition into DONE so they stay put after the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_dividend <= '0;
      div_divisor  <= '0;
      cnt_q        <= '0;
      is_rem_q     <= 1'b0;
      tag_q        <= '0;
      res_q        <= '0;
      out_tag_q    <= '0;
      dbz_q        <= 1'b0;
    end else if (accept) begin
      div_dividend <= bus.in_dividend;
      div_divisor  <= bus.in_divisor;
      is_rem_q     <= bus.in_is_rem;
      tag_q        <= bus.in_tag;
      if (fast_path) begin
        res_q     <= fast_res;
        dbz_q     <= op_div0;
        out_tag_q <= bus.in_tag;
      end else if (cache_hit) begin
        res_q     <= cache_res;
        dbz_q     <= 1'b0;
        out_tag_q <= bus.in_tag;
      end else begin
        cnt_q <= CNT_W'(LATENCY - 1);
      end
    end else if ((state_q == S_WAIT) && !flush) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        res_q     <= is_rem_q ? div_remainder : div_quotient;
        dbz_q     <= 1'b0;
        out_tag_q <= tag_q;
      end
    end
  end

  assign bus.out_result = res_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.out_dbz    = dbz_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: directed corner cases, flush/reset
// behaviour and randomized requests against a transaction-level model.
// The divider is modelled as a multicycle path: its outputs are only correct
// once the operands have been stable for LATENCY cycles.
module tb_div_issue_ctrl;
  localparam int unsigned LAT = 4;
  localparam int unsigned TW  = 5;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        busy;

  div_issue_ctrl_if #(.TAG_W(TW)) bus ();

  div_issue_ctrl #(.LATENCY(LAT), .TAG_W(TW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .bus           (bus),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // ---------------- divider environment model ----------------
  int unsigned age = 0;
  logic [31:0] pa = '0;
  logic [31:0] pb = '0;
  logic [31:0] tq;
  logic [31:0] tr;

  always @(posedge clk) begin
    #1;
    if (div_dividend !== pa || div_divisor !== pb) age = 1;
    else if (age < 1000) age++;
    pa = div_dividend;
    pb = div_divisor;
  end

  always_comb begin
    tq = 32'hDEAD_0001;
    tr = 32'hDEAD_0002;
    if (div_divisor != 0 && !(div_dividend == MIN && div_divisor == '1)) begin
      tq = $signed(div_dividend) / $signed(div_divisor);
      tr = $signed(div_dividend) % $signed(div_divisor);
    end
    div_quotient  = (age >= LAT) ? tq : ~tq;
    div_remainder = (age >= LAT) ? tr : ~tr;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic        cache_vld = 1'b0;
  logic [31:0] ca = '0;
  logic [31:0] cb = '0;

  function automatic logic [32:0] ref_op(input logic [31:0] a, input logic [31:0] b,
                                         input logic rem);
    logic [31:0] q, r;
    logic        dbz;
    dbz = 1'b0;
    if (b == 0) begin
      q = '1; r = a; dbz = 1'b1;
    end else if (a == MIN && b == '1) begin
      q = MIN; r = '0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {dbz, rem ? r : q};
  endfunction

  function automatic logic is_fast(input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (a == MIN && b == '1) || (b == MIN);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!bus.in_ready && k < 20) begin
      step();
      k++;
    end
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic rem,
                        input logic [4:0] tag, input int unsigned hold);
    logic [32:0] e;
    logic        hit;
    int unsigned exp_lat;
    int unsigned n;
    e   = ref_op(a, b, rem);
    hit = 1'b0;
`ifdef DIV_REM_FUSE_EN
    hit = cache_vld && a == ca && b == cb && !is_fast(a, b);
`endif
    exp_lat = (is_fast(a, b) || hit) ? 1 : LAT + 1;
    wait_ready();
    bus.in_valid    = 1'b1;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    bus.in_is_rem   = rem;
    bus.in_tag      = tag;
    bus.out_ready   = (hold == 0);
    step();
    bus.in_valid    = 1'b0;
    bus.in_dividend = $urandom;
    bus.in_divisor  = $urandom;
    bus.in_is_rem   = 1'($urandom);
    bus.in_tag      = 5'($urandom);
    n = 1;
    while (!bus.out_valid && n < LAT + 4) begin
      chk("opnd_a_hold", div_dividend, a);
      chk("opnd_b_hold", div_divisor, b);
      step();
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("out_valid", 32'(bus.out_valid), 32'd1);
    chk("result", bus.out_result, e[31:0]);
    chk("dbz", 32'(bus.out_dbz), 32'(e[32]));
    chk("tag", 32'(bus.out_tag), 32'(tag));
    chk("in_ready_done", 32'(bus.in_ready), 32'd0);
    chk("busy_done", 32'(busy), 32'd1);
    for (int unsigned i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_result", bus.out_result, e[31:0]);
      chk("hold_tag", 32'(bus.out_tag), 32'(tag));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("valid_after_hs", 32'(bus.out_valid), 32'd0);
    chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
    chk("result_kept", bus.out_result, e[31:0]);
    if (!is_fast(a, b) && !hit) begin
      cache_vld = 1'b1;
      ca = a;
      cb = b;
    end
  endtask

  task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic rem);
    wait_ready();
    bus.in_valid    = 1'b1;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    bus.in_is_rem   = rem;
    bus.in_tag      = 5'd3;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, la, lb;
    int unsigned sel, k;
    bus.in_valid = 1'b0; bus.in_dividend = '0; bus.in_divisor = '0;
    bus.in_is_rem = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b0;

    // reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", bus.out_result, 32'd0);
    chk("rst_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_dbz", 32'(bus.out_dbz), 32'd0);
    chk("rst_div_a", div_dividend, 32'd0);
    chk("rst_div_b", div_divisor, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // directed
    do_req(32'd100, -32'sd7, 1'b0, 5'd1, 0);
    chk("plan_div_100_m7", bus.out_result, 32'hFFFF_FFF2);
    do_req(-32'sd100, 32'd7, 1'b1, 5'd2, 0);
    chk("plan_rem_m100_7", bus.out_result, 32'hFFFF_FFFE);
    do_req(32'h1234_5678, 32'd0, 1'b0, 5'd3, 0);
    do_req(32'h1234_5678, 32'd0, 1'b1, 5'd4, 1);
    do_req(MIN, 32'hFFFF_FFFF, 1'b0, 5'd5, 0);
    do_req(MIN, 32'hFFFF_FFFF, 1'b1, 5'd6, 0);
    do_req(MIN, MIN, 1'b0, 5'd7, 0);
    do_req(32'd5, MIN, 1'b0, 5'd8, 0);
    do_req(32'd5, MIN, 1'b1, 5'd9, 0);
    do_req(32'd49, 32'd7, 1'b0, 5'd10, 10);
    chk("plan_div_49_7", bus.out_result, 32'd7);

    // fusing sequence (latency expectation follows the build)
    do_req(32'd1000, 32'd33, 1'b0, 5'd11, 0);
    do_req(32'd1000, 32'd33, 1'b1, 5'd12, 0);
    do_req(32'd1000, 32'd34, 1'b1, 5'd13, 0);

    // flush in cycle 2 of WAIT
    start_req(32'd77, 32'd5, 1'b0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_keep_a", div_dividend, 32'd77);
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      step();
      chk("flush_no_valid", 32'(bus.out_valid), 32'd0);
    end

    // flush together with in_valid in IDLE captures nothing
    bus.in_valid = 1'b1; bus.in_dividend = 32'd3; bus.in_divisor = 32'd1;
    flush = 1'b1;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_idle_busy", 32'(busy), 32'd0);
    chk("flush_idle_keep_a", div_dividend, 32'd77);

    // reset mid-WAIT
    start_req(32'd200, 32'd9, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("amid_busy", 32'(busy), 32'd0);
    chk("amid_in_ready", 32'(bus.in_ready), 32'd1);
    chk("amid_valid", 32'(bus.out_valid), 32'd0);
    chk("amid_div_a", div_dividend, 32'd0);
    chk("amid_result", bus.out_result, 32'd0);
    cache_vld = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < int'(LAT) + 2; i++) begin
      step();
      chk("amid_no_valid", 32'(bus.out_valid), 32'd0);
    end
    do_req(32'd9, 32'd3, 1'b0, 5'd14, 0);
    chk("plan_div_9_3", bus.out_result, 32'd3);

    // flush with out_ready in DONE drops the result
    start_req(32'd50, 32'd5, 1'b0);
    k = 0;
    while (!bus.out_valid && k < LAT + 4) begin
      step();
      k++;
    end
    chk("fdone_valid", 32'(bus.out_valid), 32'd1);
    cache_vld = 1'b1; ca = 32'd50; cb = 32'd5;
    flush = 1'b1; bus.out_ready = 1'b1;
    step();
    flush = 1'b0; bus.out_ready = 1'b0;
    chk("fdone_dropped", 32'(bus.out_valid), 32'd0);
    chk("fdone_in_ready", 32'(bus.in_ready), 32'd1);
    chk("fdone_result_kept", bus.out_result, 32'd10);

    // randomized
    la = 32'd1; lb = 32'd1;
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      case (sel)
        0: b = '0;
        1: begin a = MIN; b = '1; end
        2: b = MIN;
        3: a = MIN;
        4, 5: begin
          a = 32'($signed($urandom_range(0, 2000)) - 1000);
          b = 32'($signed($urandom_range(0, 40)) - 20);
        end
        6: begin a = la; b = lb; end
        default: ;
      endcase
      do_req(a, b, 1'($urandom), 5'($urandom), $urandom_range(0, 2));
      la = a; lb = b;
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
